nn_stream_ctrl: RTL and testbench

- Sequencer between the AXI-Stream pad interface and the TCB neural-network core.
- Accepts one input image as a fixed-length frame of 32-bit words and writes each word into the core's input buffer.
- Starts inference, waits for completion, then returns the 4-bit class as a single-beat output frame.
- Discards malformed frames (wrong length vs s_axis_last) and flags them.

---
 rtl/nn_pkg.sv | 17 +
 rtl/nn_busy_watchdog.sv | 31 +++
 rtl/nn_stream_ctrl.sv | 145 ++++++++++++++
 tb/tb_nn_stream_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared types and constants for the neural-network stream controller.
//   state_t    : sequencer states
//   constants  : default frame length, class width, error class code
//   addr_w()   : width of a word address for an n-word buffer (min 1)
package nn_pkg;

  typedef enum logic [2:0] {LOAD, DRAIN, START, BUSY, OUT} state_t;

  localparam int WORDS_PER_FRAME = 25;
  localparam int CLASS_W         = 4;
  localparam logic [CLASS_W-1:0] ERR_CLASS = {CLASS_W{1'b1}};

  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nn_busy_watchdog.sv
// Counts cycles spent waiting on the core; expire is high on the cycle the
// count reaches TIMEOUT_CYC-1 while busy. The count sits at zero whenever
// busy is low, so it restarts from zero on every entry into the wait.
//   clk, rst : clock, synchronous active-high reset
//   busy     : controller is waiting for core completion
//   expire   : wait limit reached this cycle
module nn_busy_watchdog #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic busy,
  output logic expire
);

  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d  = busy ? cnt_q + 1'b1 : '0;
    expire = busy && (cnt_q == LIMIT);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/nn_stream_ctrl.sv
// Sequencer between an AXI-Stream input/output pair and the NN core.
// Loads one fixed-length frame into the core input buffer, pulses start,
// waits for done and returns the class as a one-beat output frame.
// Frames whose length disagrees with s_axis_last are dropped and flagged.
//   axi_clk/axi_reset : clock, synchronous active-high reset
//   s_axis_*          : input word stream (ready in LOAD/DRAIN only)
//   m_axis_*          : single-beat class result, last always set with valid
//   core_wr_*         : core input-buffer write port
//   core_start/done   : inference handshake, core_class valid with done
//   frame_err         : one-cycle error pulse
// Optional macro NN_TIMEOUT_EN: bounds the BUSY wait at TIMEOUT_CYC cycles,
// returning the all-ones class with a frame_err pulse on expiry.
module nn_stream_ctrl
  import nn_pkg::*;
#(
  parameter int DATA_W          = 32,
  parameter int WORDS_PER_FRAME = nn_pkg::WORDS_PER_FRAME,
  parameter int CLASS_W         = nn_pkg::CLASS_W
`ifdef NN_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC     = 1024
`endif
) (
  input  logic                                axi_clk,
  input  logic                                axi_reset,
  input  logic                                s_axis_valid,
  input  logic [DATA_W-1:0]                   s_axis_data,
  input  logic                                s_axis_last,
  output logic                                s_axis_ready,
  output logic                                m_axis_valid,
  output logic [CLASS_W-1:0]                  m_axis_data,
  output logic                                m_axis_last,
  input  logic                                m_axis_ready,
  output logic                                core_wr_en,
  output logic [addr_w(WORDS_PER_FRAME)-1:0]  core_wr_addr,
  output logic [DATA_W-1:0]                   core_wr_data,
  output logic                                core_start,
  input  logic                                core_done,
  input  logic [CLASS_W-1:0]                  core_class,
  output logic                                frame_err
);

  localparam int AW = addr_w(WORDS_PER_FRAME);
  localparam logic [AW-1:0] LAST_IDX = AW'(WORDS_PER_FRAME - 1);

  state_t               state_q, state_d;
  logic [AW-1:0]        cnt_q, cnt_d;
  logic [CLASS_W-1:0]   result_q, result_d;
  logic                 frame_err_q, frame_err_d;
  logic                 accept;

`ifdef NN_TIMEOUT_EN
  logic wd_expire;

  nn_busy_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wd (
    .clk    (axi_clk),
    .rst    (axi_reset),
    .busy   (state_q == BUSY),
    .expire (wd_expire)
  );
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    result_d     = result_q;
    frame_err_d  = 1'b0;
    s_axis_ready = (state_q == LOAD) || (state_q == DRAIN);
    accept       = s_axis_valid && s_axis_ready;
    core_wr_en   = 1'b0;
    core_wr_addr = cnt_q;
    core_wr_data = s_axis_data;
    core_start   = 1'b0;
    m_axis_valid = 1'b0;
    m_axis_last  = 1'b0;
    m_axis_data  = '0;

    case (state_q)
      LOAD: begin
        core_wr_en = accept;
        if (accept) begin
          if (s_axis_last) begin
            cnt_d = '0;
            if (cnt_q == LAST_IDX) state_d = START;
            else                   frame_err_d = 1'b1;  // short frame
          end else if (cnt_q == LAST_IDX) begin
            // long frame: swallow the rest up to its last beat
            cnt_d       = '0;
            state_d     = DRAIN;
            frame_err_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (accept && s_axis_last) begin
          cnt_d   = '0;
          state_d = LOAD;
        end
      end
      START: begin
        core_start = 1'b1;
        state_d    = BUSY;
      end
      BUSY: begin
        if (core_done) begin
          result_d = core_class;
          state_d  = OUT;
        end
`ifdef NN_TIMEOUT_EN
        else if (wd_expire) begin
          result_d    = {CLASS_W{1'b1}};
          frame_err_d = 1'b1;
          state_d     = OUT;
        end
`endif
      end
      OUT: begin
        m_axis_valid = 1'b1;
        m_axis_last  = 1'b1;
        m_axis_data  = result_q;
        if (m_axis_ready) state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  assign frame_err = frame_err_q;

  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      state_q     <= LOAD;
      cnt_q       <= '0;
      result_q    <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      frame_err_q <= frame_err_d;
    end
  end

endmodule

// File: tb/tb_nn_stream_ctrl.sv
module tb_nn_stream_ctrl;

  localparam int WPF = 25;

  logic        clk = 1'b0;
  logic        axi_reset;
  logic        s_valid, s_last, s_ready;
  logic [31:0] s_data;
  logic        m_valid, m_last, m_ready;
  logic [3:0]  m_data;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        c_start, c_done, f_err;
  logic [3:0]  c_class;

  always #5 clk = ~clk;

  nn_stream_ctrl dut (
    .axi_clk(clk), .axi_reset(axi_reset),
    .s_axis_valid(s_valid), .s_axis_data(s_data), .s_axis_last(s_last), .s_axis_ready(s_ready),
    .m_axis_valid(m_valid), .m_axis_data(m_data), .m_axis_last(m_last), .m_axis_ready(m_ready),
    .core_wr_en(wr_en), .core_wr_addr(wr_addr), .core_wr_data(wr_data),
    .core_start(c_start), .core_done(c_done), .core_class(c_class), .frame_err(f_err)
  );

  int checks = 0, failures = 0;
  int cyc = 0;

  typedef struct { int addr; logic [31:0] data; int c; } wr_t;
  wr_t wr_q[$];
  int start_cnt = 0, start_cyc = -1, err_cnt = 0, err_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  // observe DUT events mid-cycle
  always @(negedge clk) begin
    if (wr_en) wr_q.push_back('{int'(wr_addr), wr_data, cyc});
    if (c_start) begin start_cnt++; start_cyc = cyc; end
    if (f_err)   begin err_cnt++;   err_cyc   = cyc; end
  end

  // Reference: a frame of len beats is written up to WPF words at addresses
  // 0..; only len==WPF starts the core; any other length flags one error
  // one cycle after the last written word.
  task automatic run_frame(input int len, input int delay, input logic [3:0] cls, input int hold);
    logic [31:0] sent[$];
    logic [31:0] d;
    int st0, er0, n_wr, last_c;
    bit got, bad;
    st0 = start_cnt; er0 = err_cnt;
    wr_q.delete();
    for (int i = 0; i < len; i++) begin
      repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
      d = $urandom;
      sent.push_back(d);
      s_valid = 1'b1; s_data = d; s_last = (i == len - 1);
      got = 0;
      for (int k = 0; k < 20 && !got; k++) begin
        @(negedge clk);
        if (s_ready) got = 1;
      end
      if (!got) begin
        checks++; failures++;
        $display("FAIL s_ready_wait beat=%0d got ready=%b want 1", i, s_ready);
      end
      @(posedge clk); #1;
      s_valid = 1'b0; s_last = 1'b0;
    end
    n_wr = (len < WPF) ? len : WPF;

    if (len == WPF) begin
      got = 0;
      for (int k = 0; k < 6 && !got; k++) begin
        @(negedge clk); #1;
        if (start_cnt != st0) got = 1;
      end
      checks++;
      if (!got) begin
        failures++;
        $display("FAIL start_seen got starts=%0d want %0d", start_cnt - st0, 1);
      end
      last_c = (wr_q.size() > 0) ? wr_q[$].c : -100;
      checks++;
      if (start_cyc !== last_c + 1) begin
        failures++;
        $display("FAIL start_latency got cyc=%0d want %0d", start_cyc, last_c + 1);
      end
      checks++;
      if (s_ready !== 1'b0) begin
        failures++;
        $display("FAIL s_ready_in_start got %b want 0", s_ready);
      end
      repeat (delay) begin @(posedge clk); #1; end
      c_done = 1'b1; c_class = cls;
      @(negedge clk);
      checks++;
      if (m_valid !== 1'b0) begin
        failures++;
        $display("FAIL valid_on_done_cycle got %b want 0", m_valid);
      end
      @(posedge clk); #1;
      c_done = 1'b0; c_class = 4'($urandom);
      @(negedge clk);
      checks++;
      if (m_valid !== 1'b1 || m_data !== cls || m_last !== 1'b1 || s_ready !== 1'b0) begin
        failures++;
        $display("FAIL result got v=%b d=%h l=%b sr=%b want v=1 d=%h l=1 sr=0",
                 m_valid, m_data, m_last, s_ready, cls);
      end
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        c_class = 4'($urandom);
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b1 || m_data !== cls || m_last !== 1'b1 || s_ready !== 1'b0) begin
          failures++;
          $display("FAIL hold_stable h=%0d got v=%b d=%h l=%b sr=%b want v=1 d=%h l=1 sr=0",
                   h, m_valid, m_data, m_last, s_ready, cls);
        end
      end
      @(posedge clk); #1;
      m_ready = 1'b1;
      @(posedge clk); #1;
      m_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
        failures++;
        $display("FAIL after_handshake got v=%b sr=%b want v=0 sr=1", m_valid, s_ready);
      end
      checks++;
      if (err_cnt != er0) begin
        failures++;
        $display("FAIL good_frame_err got pulses=%0d want 0", err_cnt - er0);
      end
    end else begin
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if (err_cnt - er0 != 1 || start_cnt != st0) begin
        failures++;
        $display("FAIL bad_frame got err=%0d start=%0d want err=1 start=0",
                 err_cnt - er0, start_cnt - st0);
      end
      last_c = (wr_q.size() > 0) ? wr_q[$].c : -100;
      checks++;
      if (err_cyc !== last_c + 1) begin
        failures++;
        $display("FAIL err_timing got cyc=%0d want %0d", err_cyc, last_c + 1);
      end
      checks++;
      if (s_ready !== 1'b1) begin
        failures++;
        $display("FAIL back_to_load got sr=%b want 1", s_ready);
      end
    end

    // written words
    checks++;
    bad = (wr_q.size() != n_wr);
    for (int i = 0; i < n_wr && !bad; i++)
      if (wr_q[i].addr != i || wr_q[i].data !== sent[i]) bad = 1;
    if (bad) begin
      failures++;
      $display("FAIL writes len=%0d got n=%0d want n=%0d (addr 0..n-1 with sent data)",
               len, wr_q.size(), n_wr);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    axi_reset = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0 || m_last !== 1'b0 || m_data !== 4'd0 ||
        c_start !== 1'b0 || f_err !== 1'b0 || wr_en !== 1'b0) begin
      failures++;
      $display("FAIL reset_values got sr=%b v=%b l=%b d=%h st=%b fe=%b we=%b want 1 0 0 0 0 0 0",
               s_ready, m_valid, m_last, m_data, c_start, f_err, wr_en);
    end
    @(posedge clk); #1;
    axi_reset = 1'b0;
  endtask

  task automatic test_basic();
    run_frame(WPF, 10, 4'd7, 0);
  endtask

  task automatic test_backpressure();
    run_frame(WPF, 10, 4'd7, 5);
  endtask

  task automatic test_short_frame();
    run_frame(10, 0, 4'd0, 0);
    run_frame(WPF, 4, 4'd3, 1);
  endtask

  task automatic test_long_frame();
    run_frame(30, 0, 4'd0, 0);
    run_frame(WPF, 2, 4'd12, 0);
  endtask

  task automatic test_reset_in_busy();
    int st0;
    st0 = start_cnt;
    for (int i = 0; i < WPF; i++) begin
      s_valid = 1'b1; s_data = $urandom; s_last = (i == WPF - 1);
      @(posedge clk); #1;
    end
    s_valid = 1'b0; s_last = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    checks++;
    if (start_cnt - st0 != 1) begin
      failures++;
      $display("FAIL busy_reached got starts=%0d want 1", start_cnt - st0);
    end
    axi_reset = 1'b1;
    @(posedge clk); #1;
    axi_reset = 1'b0;
    c_done = 1'b1; c_class = 4'd9;
    @(posedge clk); #1;
    c_done = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (m_valid !== 1'b0 || m_data !== 4'd0 || s_ready !== 1'b1) begin
        failures++;
        $display("FAIL reset_abandon k=%0d got v=%b d=%h sr=%b want v=0 d=0 sr=1",
                 k, m_valid, m_data, s_ready);
      end
      @(posedge clk); #1;
    end
    run_frame(WPF, 3, 4'd5, 0);
  endtask

  task automatic test_random();
    int len, r;
    for (int n = 0; n < 8; n++) begin
      r = $urandom_range(0, 3);
      if (r < 2)       len = WPF;
      else if (r == 2) len = $urandom_range(1, WPF - 1);
      else             len = $urandom_range(WPF + 1, WPF + 9);
      run_frame(len, $urandom_range(1, 15), 4'($urandom), $urandom_range(0, 3));
    end
  endtask

`ifdef NN_TIMEOUT_EN
  task automatic test_timeout();
    int st0, er0, vc;
    bit got;
    st0 = start_cnt; er0 = err_cnt;
    for (int i = 0; i < WPF; i++) begin
      s_valid = 1'b1; s_data = $urandom; s_last = (i == WPF - 1);
      @(posedge clk); #1;
    end
    s_valid = 1'b0; s_last = 1'b0;
    got = 0; vc = -1;
    for (int k = 0; k < 1200 && !got; k++) begin
      @(negedge clk);
      if (m_valid) begin got = 1; vc = cyc; end
    end
    #1;
    checks++;
    if (!got || m_data !== 4'hF || m_last !== 1'b1 || vc != start_cyc + 1025 ||
        err_cnt - er0 != 1 || err_cyc != vc || start_cnt - st0 != 1) begin
      failures++;
      $display("FAIL timeout got v=%b d=%h l=%b vcyc=%0d ecyc=%0d errs=%0d want d=f l=1 vcyc=%0d ecyc=vcyc errs=1",
               got, m_data, m_last, vc, err_cyc, err_cnt - er0, start_cyc + 1025);
    end
    @(posedge clk); #1;
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
  endtask
`endif

  initial begin
    axi_reset = 1'b1;
    s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    m_ready = 1'b0; c_done = 1'b0; c_class = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_short_frame();
    test_long_frame();
    test_reset_in_busy();
    test_random();
`ifdef NN_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
